kyber_comp_decomp: RTL and testbench
====================================

Name:
kyber_comp_decomp

Overview:
- Paired Kyber coefficient datapath holding two sub-blocks: a compressor and a decompressor.
- Compressor maps 8 packed 12-bit coefficients mod q to 1-, 4- and 10-bit compressed values.
- Decompressor maps 8 packed d-bit values back to 12-bit coefficients.
- Sits between the coder's RAM port (96-bit words) and its packed ciphertext/message registers; each direction has a 1-cycle registered latency.

Parameters:
- Q, 3329, Kyber modulus.
- LANES, 8, coefficients processed per cycle (fixed; port widths assume 8).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- d  in  4  compression width select (1, 4 or 10)
- in_data  in  96  compressor input; lane i = bits [12i+11:12i]
- out_data_d1  out  8  compressed d=1; lane i = bit i
- out_data_d4  out  32  compressed d=4; lane i = bits [4i+3:4i]
- out_data_d10  out  80  compressed d=10; lane i = bits [10i+9:10i]
- in_data_d1  in  8  decompressor input for d=1; lane i = bit i
- in_data_d4  in  32  decompressor input for d=4
- in_data_d10  in  80  decompressor input for d=10
- out_data  out  96  decompressed result; lane i = bits [12i+11:12i]

Behaviour:
- Reset: all output registers (out_data_d1/d4/d10, out_data) clear to 0 immediately on rst high, independent of clk. Reset mid-operation discards in-flight results.
- Compress, per lane x (12-bit unsigned): C_d(x) = floor((x*2^d + (Q-1)/2) / Q) mod 2^d, with (Q-1)/2 = 1664.
  - The mod 2^d wrap is required: x near Q rounds to 2^d, which must wrap to 0.
  - Intermediate width at least 23 bits for d=10.
- All three compressed outputs are computed in parallel every cycle. Each is registered on every rising clk edge from the current in_data.
  - Latency: 1 cycle. in_data in cycle n appears on out_data_d* in cycle n+1.
  - The compressor ignores d. The caller picks the output width it needs.
- Compressor inputs x >= Q are not rejected; the same formula applies to the full 12-bit range.
- Decompress, per lane y: D_d(y) = floor((y*Q + 2^(d-1)) / 2^d), zero-extended to 12 bits.
  - The input source is selected by the current d: d=1 uses in_data_d1, d=4 uses in_data_d4, d=10 uses in_data_d10.
  - Result registered each rising edge. Latency: 1 cycle; d and the input are sampled in the same cycle.
- Any other value of d: out_data loads 0 on the next edge.
- Sampling changes of d: a d change takes effect for decompression on the very edge at which it is sampled, with no pipeline bubble. The compressor is unaffected.
- No handshake, no valid signals: continuous streaming, one word per cycle.
- Arithmetic is purely combinational before the output registers. Division by Q may be implemented by multiply-shift, provided results match the formulas above for every input in range.

Test Plan:
- Reset: assert rst asynchronously mid-clock with nonzero inputs -> all outputs 0 immediately; after release, the first clock edge loads valid results.
- Compress d=1 sweep, all 8 lanes, one value per lane per cycle:
  - x = 0, 832, 833, 2496, 2497, 3328 -> bits 0, 0, 1, 1, 0, 0, one cycle later.
- Compress d=4/d=10, same cycle:
  - x = 1000 -> d4 = 5.
  - x = 1665 -> d10 = 512.
  - x = 3328 -> d10 = 0 (wrap).
  - Lane packing verified by placing distinct values per lane.
- Decompress:
  - d=1: y = 1 -> 1665; y = 0 -> 0.
  - d=4: y = 15 -> 3121.
  - d=10: y = 1023 -> 3326; y = 512 -> 1665.
  - Each result appears one cycle after input, in the correct 12-bit lane.
- Streaming with d switching 10 -> 4 between consecutive cycles -> each out_data word reflects the d and input of its own sample cycle; d = 0 -> out_data = 0.
- Round-trip, random x in [0, 3328], d in {1, 4, 10} -> |D_d(C_d(x)) - x| mod± Q <= round(Q / 2^(d+1)) for every lane.

Source files
------------

// File: rtl/kyber_comp_decomp.sv
// kyber_comp_decomp: 8-lane Kyber compress (d=1/4/10) and decompress datapath.
// Both directions are registered with one cycle of latency.
module kyber_comp_decomp #(
    parameter int Q     = 3329,
    parameter int LANES = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  d,
    input  logic [95:0] in_data,
    output logic [7:0]  out_data_d1,
    output logic [31:0] out_data_d4,
    output logic [79:0] out_data_d10,
    input  logic [7:0]  in_data_d1,
    input  logic [31:0] in_data_d4,
    input  logic [79:0] in_data_d10,
    output logic [95:0] out_data
);
    localparam int H = (Q - 1) / 2;

    logic [7:0]  w_c1;
    logic [31:0] w_c4;
    logic [79:0] w_c10;
    logic [95:0] w_dec;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [11:0] w_x;
        logic [23:0] w_n1, w_n4, w_n10;
        logic [23:0] w_p1, w_p4, w_p10;
        assign w_x   = in_data[12*i +: 12];
        assign w_n1  = {11'b0, w_x, 1'b0} + 24'(H);
        assign w_n4  = {8'b0, w_x, 4'b0} + 24'(H);
        assign w_n10 = {2'b0, w_x, 10'b0} + 24'(H);
        // Truncating the quotient performs the mod 2^d wrap (x near Q -> 0)
        assign w_c1[i]          = 1'(w_n1 / 24'(Q));
        assign w_c4[4*i +: 4]   = 4'(w_n4 / 24'(Q));
        assign w_c10[10*i +: 10] = 10'(w_n10 / 24'(Q));
        assign w_p1  = 24'(in_data_d1[i]) * 24'(Q) + 24'd1;
        assign w_p4  = 24'(in_data_d4[4*i +: 4]) * 24'(Q) + 24'd8;
        assign w_p10 = 24'(in_data_d10[10*i +: 10]) * 24'(Q) + 24'd512;
        assign w_dec[12*i +: 12] = (d == 4'd1)  ? 12'(w_p1 >> 1)   :
                                   (d == 4'd4)  ? 12'(w_p4 >> 4)   :
                                   (d == 4'd10) ? 12'(w_p10 >> 10) : 12'd0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data_d1  <= '0;
            out_data_d4  <= '0;
            out_data_d10 <= '0;
            out_data     <= '0;
        end else begin
            out_data_d1  <= w_c1;
            out_data_d4  <= w_c4;
            out_data_d10 <= w_c10;
            out_data     <= w_dec;
        end
    end
endmodule

// File: tb/tb_kyber_comp_decomp.sv
// tb_kyber_comp_decomp: directed and random checks of compress/decompress
// against an arithmetic reference model of the Kyber formulas.
module tb_kyber_comp_decomp;
    localparam int Q = 3329;

    logic        clk = 0;
    logic        rst;
    logic [3:0]  d;
    logic [95:0] in_data;
    logic [7:0]  out_data_d1;
    logic [31:0] out_data_d4;
    logic [79:0] out_data_d10;
    logic [7:0]  in_data_d1;
    logic [31:0] in_data_d4;
    logic [79:0] in_data_d10;
    logic [95:0] out_data;

    int total = 0;
    int bad   = 0;

    kyber_comp_decomp dut (
        .clk(clk), .rst(rst), .d(d), .in_data(in_data),
        .out_data_d1(out_data_d1), .out_data_d4(out_data_d4), .out_data_d10(out_data_d10),
        .in_data_d1(in_data_d1), .in_data_d4(in_data_d4), .in_data_d10(in_data_d10),
        .out_data(out_data)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    function automatic int cmp(int x, int dd);
        return (((x * (1 << dd)) + (Q - 1) / 2) / Q) % (1 << dd);
    endfunction

    function automatic int dcm(int y, int dd);
        return (y * Q + (1 << (dd - 1))) / (1 << dd);
    endfunction

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one word, wait for the capturing edge, compare every output.
    task automatic step(input logic [95:0] xi, input logic [3:0] di,
                        input logic [7:0] a1, input logic [31:0] a4, input logic [79:0] a10);
        logic [7:0]  e1;
        logic [31:0] e4;
        logic [79:0] e10;
        logic [95:0] eo;
        int y;
        in_data = xi; d = di; in_data_d1 = a1; in_data_d4 = a4; in_data_d10 = a10;
        for (int l = 0; l < 8; l++) begin
            e1[l]          = 1'(cmp(int'(xi[12*l +: 12]), 1));
            e4[4*l +: 4]   = 4'(cmp(int'(xi[12*l +: 12]), 4));
            e10[10*l +: 10] = 10'(cmp(int'(xi[12*l +: 12]), 10));
            case (di)
                4'd1:    y = dcm(int'(a1[l]), 1);
                4'd4:    y = dcm(int'(a4[4*l +: 4]), 4);
                4'd10:   y = dcm(int'(a10[10*l +: 10]), 10);
                default: y = 0;
            endcase
            eo[12*l +: 12] = 12'(y);
        end
        @(posedge clk);
        #1;
        chk("comp_d1", 96'(out_data_d1), 96'(e1));
        chk("comp_d4", 96'(out_data_d4), 96'(e4));
        chk("comp_d10", 96'(out_data_d10), 96'(e10));
        chk("decomp", out_data, eo);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_d1"}, 96'(out_data_d1), 96'd0);
        chk({tag, "_d4"}, 96'(out_data_d4), 96'd0);
        chk({tag, "_d10"}, 96'(out_data_d10), 96'd0);
        chk({tag, "_out"}, out_data, 96'd0);
    endtask

    initial begin
        logic [95:0] xv;
        logic [7:0]  c1;
        logic [31:0] c4;
        logic [79:0] c10;
        logic [3:0]  dr;
        int xs[8];
        int dd, bound, diff;
        bit ok;

        rst = 1;
        d = 4'd10;
        in_data = {8{12'd1234}};
        in_data_d1 = 8'hff; in_data_d4 = '1; in_data_d10 = '1;
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        rst = 0;

        // d=1 thresholds; lanes 0..7
        xv = {12'd3327, 12'd1, 12'd3328, 12'd2497, 12'd2496, 12'd833, 12'd832, 12'd0};
        step(xv, 4'd1, 8'h00, 32'h0, 80'h0);
        chk("d1_sweep", 96'(out_data_d1), 96'(8'b0000_1100));

        // d4/d10 spot values with distinct lanes; decompress d=10 constants
        xv = {12'd3328, 12'd7, 12'd1665, 12'd300, 12'd2000, 12'd1000, 12'd50, 12'd4095};
        c10 = {10'd3, 10'd9, 10'd77, 10'd512, 10'd1023, 10'd0, 10'd512, 10'd1023};
        step(xv, 4'd10, 8'h00, 32'h0, c10);
        chk("d4_1000", 96'(out_data_d4[8 +: 4]), 96'd5);
        chk("d10_1665", 96'(out_data_d10[50 +: 10]), 96'd512);
        chk("d10_wrap", 96'(out_data_d10[70 +: 10]), 96'd0);
        chk("dec10_1023", 96'(out_data[0 +: 12]), 96'd3326);
        chk("dec10_512", 96'(out_data[12 +: 12]), 96'd1665);
        chk("dec10_1023b", 96'(out_data[36 +: 12]), 96'd3326);

        // decompress d=1 and d=4 constants; then d switches 10 -> 4 -> 0
        step(xv, 4'd1, 8'b0000_1000, 32'h0, 80'h0);
        chk("dec1_one", 96'(out_data[36 +: 12]), 96'd1665);
        chk("dec1_zero", 96'(out_data[0 +: 12]), 96'd0);
        step(xv, 4'd10, 8'hff, 32'h0f00_0000, c10);
        step(xv, 4'd4, 8'hff, 32'h0f00_0000, c10);
        chk("dec4_15", 96'(out_data[72 +: 12]), 96'd3121);
        step(xv, 4'd0, 8'hff, 32'hffff_ffff, c10);
        chk("d0_zero", out_data, 96'd0);

        // asynchronous reset mid-cycle with nonzero inputs
        step(xv, 4'd10, 8'hff, 32'hffff_ffff, c10);
        #3;
        rst = 1;
        #1;
        chk_zero("async_rst");
        #2;
        rst = 0;
        step(xv, 4'd4, 8'hff, 32'h1234_5678, c10);

        // random streaming over full 12-bit x and arbitrary d
        for (int k = 0; k < 40; k++) begin
            for (int l = 0; l < 8; l++) xv[12*l +: 12] = 12'($urandom);
            case ($urandom_range(4))
                0: dr = 4'd1;
                1: dr = 4'd4;
                2: dr = 4'd10;
                3: dr = 4'd0;
                default: dr = 4'($urandom);
            endcase
            step(xv, dr, 8'($urandom), 32'($urandom), {16'($urandom), 32'($urandom), 32'($urandom)});
        end

        // round trip: compress x, decompress the model's C_d(x), check error bound
        for (int k = 0; k < 30; k++) begin
            case (k % 3)
                0: dd = 1;
                1: dd = 4;
                default: dd = 10;
            endcase
            for (int l = 0; l < 8; l++) begin
                xs[l] = int'($urandom_range(3328));
                xv[12*l +: 12] = 12'(xs[l]);
                c1[l] = 1'(cmp(xs[l], 1));
                c4[4*l +: 4] = 4'(cmp(xs[l], 4));
                c10[10*l +: 10] = 10'(cmp(xs[l], 10));
            end
            step(xv, 4'(dd), 8'h0, 32'h0, 80'h0);
            step(xv, 4'(dd), c1, c4, c10);
            bound = (Q + (1 << dd)) / (1 << (dd + 1));
            ok = 1;
            for (int l = 0; l < 8; l++) begin
                diff = int'(out_data[12*l +: 12]) - xs[l];
                diff = ((diff % Q) + Q) % Q;
                if (diff > Q / 2) diff = Q - diff;
                if (diff > bound) ok = 0;
            end
            chk("roundtrip", 96'(ok), 96'd1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
